// File: rtl/sort_sequencer_pkg.sv
// Shared definitions for the sort sequencer: controller states and the
// default data-word width and batch depth.
package sort_sequencer_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SORT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam int unsigned SORT_N     = 32;
    localparam int unsigned SORT_DEPTH = 8;

endpackage

// File: rtl/sort_sequencer_comparator_lt.sv
// Signed N-bit less-than comparator: o_lt = (i_a < i_b) as two's-complement.
module comparator_lt #(
    parameter int unsigned N = 32
) (
    input  logic signed [N-1:0] i_a,
    input  logic signed [N-1:0] i_b,
    output logic                o_lt
);

    // Both operands are signed, so the relational operator compares signed.
    always_comb begin
        o_lt = (i_a < i_b);
    end

endmodule

// File: rtl/sort_sequencer.sv
// Batch sorter: loads DEPTH signed words, bubble-sorts them in place with a
// single shared comparator (one neighbour compare per cycle), then streams
// them out in ascending signed order over a valid/ready interface.
module sort_sequencer
    import sort_sequencer_pkg::*;
#(
    parameter int unsigned N     = SORT_N,
    parameter int unsigned DEPTH = SORT_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_PAIR = IW'(DEPTH - 2);

    state_t               r_state;
    logic [IW-1:0]        r_wr_idx;
    logic [IW-1:0]        r_rd_idx;
    logic [IW-1:0]        r_i;
    logic                 r_swap;
    logic                 r_load;
    logic                 r_busy;
    logic                 r_out_valid;
    logic signed [N-1:0]  r_mem [DEPTH];

    logic [IW-1:0]        w_i_nxt;
    logic signed [N-1:0]  w_hi;
    logic signed [N-1:0]  w_lo;
    logic                 w_lt;
    logic                 w_accept;
    logic                 w_xfer;

    // Neighbour pair under comparison and handshake qualifiers.
    always_comb begin
        w_i_nxt  = r_i + IW'(1);
        w_hi     = r_mem[w_i_nxt];
        w_lo     = r_mem[r_i];
        w_accept = in_valid & in_ready;
        w_xfer   = r_out_valid & out_ready;
    end

    // The single magnitude comparator for stored data: mem[i+1] < mem[i].
    comparator_lt #(
        .N(N)
    ) u_cmp (
        .i_a  (w_hi),
        .i_b  (w_lo),
        .o_lt (w_lt)
    );

    // Output decode. in_ready is masked by rst so it reads 0 while reset is
    // held yet is already 1 in the first cycle after release.
    always_comb begin
        in_ready  = r_load & ~rst;
        out_valid = r_out_valid;
        busy      = r_busy;
        out_data  = r_out_valid ? r_mem[r_rd_idx] : '0;
    end

    // Controller FSM: state, indices, swap flag and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_LOAD;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_i         <= '0;
            r_swap      <= 1'b0;
            r_load      <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (r_wr_idx == LAST_IDX) begin
                            r_state  <= S_SORT;
                            r_wr_idx <= '0;
                            r_i      <= '0;
                            r_swap   <= 1'b0;
                            r_load   <= 1'b0;
                            r_busy   <= 1'b1;
                        end else begin
                            r_wr_idx <= r_wr_idx + IW'(1);
                        end
                    end
                end
                S_SORT: begin
                    if (r_i == LAST_PAIR) begin
                        if (r_swap | w_lt) begin
                            r_i    <= '0;
                            r_swap <= 1'b0;
                        end else begin
                            r_state     <= S_DRAIN;
                            r_rd_idx    <= '0;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end else begin
                        r_i <= w_i_nxt;
                        if (w_lt) begin
                            r_swap <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_xfer) begin
                        if (r_rd_idx == LAST_IDX) begin
                            r_state     <= S_LOAD;
                            r_rd_idx    <= '0;
                            r_out_valid <= 1'b0;
                            r_load      <= 1'b1;
                        end else begin
                            r_rd_idx <= r_rd_idx + IW'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= S_LOAD;
                    r_wr_idx    <= '0;
                    r_rd_idx    <= '0;
                    r_i         <= '0;
                    r_swap      <= 1'b0;
                    r_load      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Batch storage: loads in S_LOAD, in-place neighbour swap in S_SORT.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_idx] <= in_data;
        end else if (r_busy && w_lt) begin
            r_mem[r_i]     <= w_hi;
            r_mem[w_i_nxt] <= w_lo;
        end
    end

endmodule
